// File: rtl/fib_index.sv
`default_nettype none
// ============================================================================
// Module      : fib_index
// Description : Finds the largest Fibonacci index n with F(n) <= f, and
//               flags whether F(n) equals f exactly. Iterative, one term/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_index #(
  parameter int W  = 20,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  f,
  output logic          ready,
  output logic          done_tick,
  output logic [IW-1:0] i,
  output logic          exact
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OP   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  f_reg_q, f_reg_d;
  logic [W-1:0]  t0_q, t0_d;
  logic [W-1:0]  t1_q, t1_d;
  logic [IW-1:0] n_q, n_d;
  logic [IW-1:0] i_q, i_d;
  logic          exact_q, exact_d;
  logic [W:0]    sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      f_reg_q <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      n_q     <= '0;
      i_q     <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f_reg_q <= f_reg_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      n_q     <= n_d;
      i_q     <= i_d;
      exact_q <= exact_d;
    end
  end

  // One extra bit on the sum keeps the final over-range term from wrapping.
  always_comb begin
    sum     = {1'b0, t0_q} + {1'b0, t1_q};
    state_d = state_q;
    f_reg_d = f_reg_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    n_d     = n_q;
    i_d     = i_q;
    exact_d = exact_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f_reg_d = f;
          t0_d    = '0;
          t1_d    = {{(W-1){1'b0}}, 1'b1};
          n_d     = {{(IW-1){1'b0}}, 1'b1};
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (f_reg_q == '0) begin
          i_d     = '0;
          exact_d = 1'b1;
          state_d = S_DONE;
        end else if (sum <= {1'b0, f_reg_q}) begin
          t0_d = t1_q;
          t1_d = sum[W-1:0];
          n_d  = n_q + IW'(1);
        end else begin
          i_d     = n_q;
          exact_d = (t1_q == f_reg_q);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE);
    done_tick = (state_q == S_DONE);
    i         = i_q;
    exact     = exact_q;
  end

endmodule
`default_nettype wire
